if_staged: RTL and testbench

- Instruction-fetch stage of the pipelined ARM datapath, directly upstream of the decode/register stage.
- Holds the PC and drives the instruction-memory address. Computes next-PC from PC+4, a conditional/unconditional branch target, or a BR register target.
- Registers the fetched instruction and its PC+4 into the IF/DEC pipeline register that feeds decode.
- Branch resolution comes back from decode, giving exactly one architectural branch delay slot. There is no flush.

---
 rtl/if_pkg.sv | 33 +++
 rtl/br_target_gen.sv | 47 ++++
 rtl/if_staged.sv | 102 ++++++++++
 tb/tb_if_staged.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared constants for the instruction-fetch stage of the pipelined ARM
// datapath: bus widths, reset defaults and the bit positions of the two
// branch-offset fields that decode hands back to fetch.
// ---------------------------------------------------------------------------
package if_pkg;

    // Bus widths.
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    // Reset defaults; the NOP is ADD X31,X31,X31.
    localparam logic [ADDR_W-1:0]  PC_RESET_DEF  = 64'h0;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h8B1F_03FF;

    // BrAddr26 field of B/BL.
    localparam int unsigned BR26_LSB = 0;
    localparam int unsigned BR26_MSB = 25;
    localparam int unsigned BR26_W   = BR26_MSB - BR26_LSB + 1;

    // CondAddr19 field of CBZ/CBNZ/B.cond.
    localparam int unsigned COND19_LSB = 5;
    localparam int unsigned COND19_MSB = 23;
    localparam int unsigned COND19_W   = COND19_MSB - COND19_LSB + 1;

    // Offsets are word counts; byte offset is the field shifted left by this.
    localparam int unsigned WORD_SHIFT = 2;

    // Sequential fetch increment.
    localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

endpackage

// File: rtl/br_target_gen.sv
// ---------------------------------------------------------------------------
// br_target_gen
// Purely combinational branch-target generator. Extracts the branch offset
// field from the instruction currently in decode, sign-extends it, converts
// the word offset into a byte offset and adds it to that instruction's PC.
//
// Ports:
//   instruction  in  32  instruction held in the IF/DEC register
//   pc_dec       in  64  PC of that instruction (branch base)
//   UncondBr     in  1   1 = BrAddr26 (B/BL), 0 = CondAddr19 (CB/B.cond)
//   br_target    out 64  pc_dec + sign-extended offset * 4 (modulo 2^64)
// ---------------------------------------------------------------------------
module br_target_gen
    import if_pkg::*;
(
    input  logic [INSTR_W-1:0] instruction,
    input  logic [ADDR_W-1:0]  pc_dec,
    input  logic               UncondBr,
    output logic [ADDR_W-1:0]  br_target
);

    localparam int unsigned Br26Ext   = ADDR_W - BR26_W - WORD_SHIFT;
    localparam int unsigned Cond19Ext = ADDR_W - COND19_W - WORD_SHIFT;

    logic [BR26_W-1:0]   br_addr26;
    logic [COND19_W-1:0] cond_addr19;
    logic [ADDR_W-1:0]   off_uncond;
    logic [ADDR_W-1:0]   off_cond;
    logic [ADDR_W-1:0]   offset;

    // Opcode bits and the register field of CB are not needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[INSTR_W-1:BR26_MSB+1]};

    always_comb begin
        br_addr26   = instruction[BR26_MSB:BR26_LSB];
        cond_addr19 = instruction[COND19_MSB:COND19_LSB];

        // Sign-extend then append two zero bits: the shift left by 2.
        off_uncond = {{Br26Ext{br_addr26[BR26_W-1]}}, br_addr26, {WORD_SHIFT{1'b0}}};
        off_cond   = {{Cond19Ext{cond_addr19[COND19_W-1]}}, cond_addr19, {WORD_SHIFT{1'b0}}};

        offset    = UncondBr ? off_uncond : off_cond;
        br_target = pc_dec + offset;
    end

endmodule

// File: rtl/if_staged.sv
// ---------------------------------------------------------------------------
// if_staged
// Instruction-fetch stage. Holds the PC (driven straight out as the
// instruction-memory address), selects the next PC and captures the fetched
// word plus its PC and PC+4 into the IF/DEC register. Branches resolve in
// decode, so the word fetched while a branch sits in DEC still enters DEC:
// one architectural delay slot, no flush.
//
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   stall        in  1   hold PC and IF/DEC register
//   BrTaken      in  1   take branch for the instruction in DEC
//   UncondBr     in  1   1 = BrAddr26 offset, 0 = CondAddr19 offset
//   pc_rd        in  1   BR: next PC = Reg2 (beats BrTaken)
//   Reg2         in  64  register value for BR
//   imem_data    in  32  instruction-memory read data for imem_addr
//   imem_addr    out 64  current fetch PC
//   instruction  out 32  IF/DEC: instruction handed to decode
//   PCPlusFour   out 64  IF/DEC: PC+4 of that instruction
//   pc_dec       out 64  IF/DEC: PC of that instruction
// ---------------------------------------------------------------------------
module if_staged
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  PC_RESET  = PC_RESET_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               BrTaken,
    input  logic               UncondBr,
    input  logic               pc_rd,
    input  logic [ADDR_W-1:0]  Reg2,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  PCPlusFour,
    output logic [ADDR_W-1:0]  pc_dec
);

    logic [ADDR_W-1:0]  pc_q,     pc_d;
    logic [INSTR_W-1:0] instr_q,  instr_d;
    logic [ADDR_W-1:0]  pcp4_q,   pcp4_d;
    logic [ADDR_W-1:0]  pc_dec_q, pc_dec_d;

    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  br_target;

    // Offset comes from the registered word in DEC, never from imem_data.
    br_target_gen u_br_target_gen (
        .instruction (instr_q),
        .pc_dec      (pc_dec_q),
        .UncondBr    (UncondBr),
        .br_target   (br_target)
    );

    always_comb begin
        pc_plus4 = pc_q + PC_INCR;

        pc_d     = pc_q;
        instr_d  = instr_q;
        pcp4_d   = pcp4_q;
        pc_dec_d = pc_dec_q;

        // While stalled the branch in DEC is simply re-evaluated later.
        if (!stall) begin
            if (pc_rd) begin
                pc_d = Reg2;
            end else if (BrTaken) begin
                pc_d = br_target;
            end else begin
                pc_d = pc_plus4;
            end

            instr_d  = imem_data;
            pc_dec_d = pc_q;
            pcp4_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            instr_q  <= NOP_INSTR;
            pcp4_q   <= PC_RESET + PC_INCR;
            pc_dec_q <= PC_RESET;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
            pc_dec_q <= pc_dec_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign PCPlusFour  = pcp4_q;
    assign pc_dec      = pc_dec_q;

endmodule

// File: tb/tb_if_staged.sv
module tb_if_staged;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        BrTaken;
    logic        UncondBr;
    logic        pc_rd;
    logic [63:0] Reg2;
    logic [31:0] imem_data;
    logic [63:0] imem_addr;
    logic [31:0] instruction;
    logic [63:0] PCPlusFour;
    logic [63:0] pc_dec;

    int n_pass  = 0;
    int n_total = 0;

    // Sparse instruction memory; unwritten addresses return a hash.
    logic [31:0] mem [logic [63:0]];
    int          mem_gen = 0;

    // Reference state of the fetch stage.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [63:0] m_pcp4;
    logic [63:0] m_pcdec;

    localparam logic [31:0] NOP = 32'h8B1F03FF;

    if_staged dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .pc_rd       (pc_rd),
        .Reg2        (Reg2),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .instruction (instruction),
        .PCPlusFour  (PCPlusFour),
        .pc_dec      (pc_dec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_lookup(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0BADF00D;
    endfunction

    always @(imem_addr or mem_gen) imem_data = mem_lookup(imem_addr);

    // Byte offset of the branch in DEC, from the ISA field definitions.
    function automatic longint branch_offset(input logic [31:0] ins, input logic unc);
        logic signed [25:0] f26;
        logic signed [18:0] f19;
        f26 = ins[25:0];
        f19 = ins[23:5];
        if (unc) return longint'(f26) * 4;
        return longint'(f19) * 4;
    endfunction

    // One clock: advance the model from pre-edge inputs, then sample #1 later.
    task automatic tick();
        logic [63:0] n_pc, n_pcp4, n_pcdec;
        logic [31:0] n_instr;
        n_pc = m_pc; n_instr = m_instr; n_pcp4 = m_pcp4; n_pcdec = m_pcdec;
        if (reset) begin
            n_pc = 64'h0; n_instr = NOP; n_pcp4 = 64'h4; n_pcdec = 64'h0;
        end else if (!stall) begin
            if (pc_rd)        n_pc = Reg2;
            else if (BrTaken) n_pc = m_pcdec + 64'(branch_offset(m_instr, UncondBr));
            else              n_pc = m_pc + 64'd4;
            n_instr = mem_lookup(m_pc);
            n_pcdec = m_pc;
            n_pcp4  = m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pcp4 = n_pcp4; m_pcdec = n_pcdec;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
        pc_rd = 1'b0; Reg2 = 64'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (imem_addr !== 64'h0) $display("FAIL reset_pc got %h want %h", imem_addr, 64'h0);
        else n_pass++;
        n_total++;
        if (instruction !== 32'h8B1F03FF)
            $display("FAIL reset_instr got %h want %h", instruction, 32'h8B1F03FF);
        else n_pass++;
        n_total++;
        if (PCPlusFour !== 64'h4) $display("FAIL reset_pcp4 got %h want %h", PCPlusFour, 64'h4);
        else n_pass++;
        n_total++;
        if (pc_dec !== 64'h0) $display("FAIL reset_pcdec got %h want %h", pc_dec, 64'h0);
        else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) mem[64'(i * 4)] = $urandom;
        mem_gen++;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_total++;
            if (imem_addr !== 64'(i * 4))
                $display("FAIL seq_pc[%0d] got %h want %h", i, imem_addr, 64'(i * 4));
            else n_pass++;
            n_total++;
            if (instruction !== mem[64'((i - 1) * 4)])
                $display("FAIL seq_instr[%0d] got %h want %h", i, instruction,
                         mem[64'((i - 1) * 4)]);
            else n_pass++;
            n_total++;
            if (pc_dec !== 64'((i - 1) * 4) || PCPlusFour !== 64'(i * 4))
                $display("FAIL seq_dec[%0d] got pc_dec=%h pcp4=%h want %h %h", i, pc_dec,
                         PCPlusFour, 64'((i - 1) * 4), 64'(i * 4));
            else n_pass++;
        end
    endtask

    task automatic test_uncond_branch();
        mem[64'h8]  = 32'h14000003;  // B +3 words
        mem[64'hC]  = 32'hAAAA0001;
        mem[64'h14] = 32'hAAAA0005;
        mem_gen++;
        do_reset();
        tick(); tick(); tick();  // B now in DEC with pc_dec = 8
        n_total++;
        if (pc_dec !== 64'h8 || instruction !== 32'h14000003)
            $display("FAIL ub_setup got pc_dec=%h instr=%h want 8 14000003", pc_dec, instruction);
        else n_pass++;
        BrTaken = 1'b1; UncondBr = 1'b1;
        tick();
        BrTaken = 1'b0;
        n_total++;
        if (imem_addr !== 64'h14) $display("FAIL ub_target got %h want %h", imem_addr, 64'h14);
        else n_pass++;
        n_total++;
        if (instruction !== 32'hAAAA0001 || pc_dec !== 64'hC)
            $display("FAIL ub_delay_slot got %h@%h want aaaa0001@c", instruction, pc_dec);
        else n_pass++;
        tick();
        n_total++;
        if (instruction !== 32'hAAAA0005 || imem_addr !== 64'h18)
            $display("FAIL ub_target_instr got %h pc=%h want aaaa0005 pc=18", instruction,
                     imem_addr);
        else n_pass++;
    endtask

    task automatic test_backward_cond();
        mem[64'h20] = 32'hB4FFFFC0;  // CBZ with CondAddr19 = 19'h7FFFE (-2 words)
        mem_gen++;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            pc_rd = 1'b1; Reg2 = 64'h20;
            tick();
            pc_rd = 1'b0;
            tick();  // CBZ enters DEC, PC = 0x24
            BrTaken = (k == 1); UncondBr = 1'b0;
            tick();
            BrTaken = 1'b0;
            n_total++;
            if (imem_addr !== ((k == 1) ? 64'h18 : 64'h28))
                $display("FAIL cb_next[%0d] got %h want %h", k, imem_addr,
                         (k == 1) ? 64'h18 : 64'h28);
            else n_pass++;
        end
    endtask

    task automatic test_br_priority();
        mem[64'h8] = 32'h14000003;
        mem_gen++;
        do_reset();
        tick(); tick(); tick();
        pc_rd = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1; Reg2 = 64'h40;
        tick();
        idle_inputs();
        n_total++;
        if (imem_addr !== 64'h40) $display("FAIL br_priority got %h want %h", imem_addr, 64'h40);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] held_instr;
        mem[64'h8] = 32'h14000003;
        mem_gen++;
        do_reset();
        tick(); tick(); tick();  // B in DEC, PC = 0xC
        held_instr = mem_lookup(64'h8);
        stall = 1'b1; BrTaken = 1'b1; UncondBr = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_total++;
            if (imem_addr !== 64'hC || instruction !== held_instr || pc_dec !== 64'h8)
                $display("FAIL stall_hold[%0d] got pc=%h instr=%h pc_dec=%h want c %h 8", c,
                         imem_addr, instruction, pc_dec, held_instr);
            else n_pass++;
        end
        stall = 1'b0;
        tick();
        BrTaken = 1'b0;
        n_total++;
        if (imem_addr !== 64'h14) $display("FAIL stall_release got %h want %h", imem_addr, 64'h14);
        else n_pass++;
    endtask

    task automatic test_reset_mid_and_wrap();
        mem[64'h8] = 32'h14000003;
        mem_gen++;
        do_reset();
        tick(); tick(); tick();
        BrTaken = 1'b1; UncondBr = 1'b1; reset = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (imem_addr !== 64'h0 || instruction !== NOP)
            $display("FAIL reset_mid got pc=%h instr=%h want 0 %h", imem_addr, instruction, NOP);
        else n_pass++;
        pc_rd = 1'b1; Reg2 = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        pc_rd = 1'b0;
        tick();
        n_total++;
        if (imem_addr !== 64'h0) $display("FAIL wrap_pc got %h want %h", imem_addr, 64'h0);
        else n_pass++;
        n_total++;
        if (PCPlusFour !== 64'h0 || pc_dec !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL wrap_pcp4 got pcp4=%h pc_dec=%h want 0 fffffffffffffffc",
                     PCPlusFour, pc_dec);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 5) == 0);
            BrTaken  = ($urandom_range(0, 3) == 0);
            UncondBr = $urandom_range(0, 1) == 1;
            pc_rd    = ($urandom_range(0, 9) == 0);
            Reg2     = {$urandom, $urandom};
            tick();
            n_total++;
            if (imem_addr !== m_pc || instruction !== m_instr || PCPlusFour !== m_pcp4 ||
                pc_dec !== m_pcdec)
                $display("FAIL rand[%0d] got pc=%h ins=%h p4=%h pd=%h want %h %h %h %h", c,
                         imem_addr, instruction, PCPlusFour, pc_dec, m_pc, m_instr, m_pcp4,
                         m_pcdec);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        m_pc = '0; m_instr = '0; m_pcp4 = '0; m_pcdec = '0;
        test_reset();
        test_sequential();
        test_uncond_branch();
        test_backward_cond();
        test_br_priority();
        test_stall();
        test_reset_mid_and_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
